// File: rtl/axi_rd_arbiter.sv
// Two-master, one-outstanding read arbiter in front of the AXI read channel block.
// Grants m0 (IFU) or m1 (LSU), forwards the request downstream, routes beats back and checks burst length.
module axi_rd_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ID_W   = 4,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_ar_valid,
  output logic              m0_ar_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic [1:0]        m0_size,
  output logic              m0_r_valid,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [1:0]        m0_r_resp,
  output logic              m0_r_last,
  input  logic              m1_ar_valid,
  output logic              m1_ar_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [1:0]        m1_size,
  output logic              m1_r_valid,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [1:0]        m1_r_resp,
  output logic              m1_r_last,
  output logic              s_ar_valid,
  input  logic              s_ar_ready,
  output logic [ID_W-1:0]   s_ar_id,
  output logic [ADDR_W-1:0] s_addr,
  output logic [LEN_W-1:0]  s_len,
  output logic [1:0]        s_size,
  input  logic              s_r_valid,
  output logic              s_r_ready,
  input  logic [DATA_W-1:0] s_r_data,
  input  logic [1:0]        s_r_resp,
  input  logic              s_r_last,
  output logic              err_len,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [1:0]        r_size;
  logic [LEN_W:0]    r_cnt;

  logic              w_win;
  logic              w_grant;
  logic              w_beat;
  logic              w_cnt_match;

  // w_win: 1 selects m1. Round-robin favours the master not granted last time.
  always_comb begin
    if (m0_ar_valid && m1_ar_valid) begin
      w_win = RR_EN ? ~r_last_grant : 1'b1;
    end else begin
      w_win = m1_ar_valid;
    end
  end

  always_comb begin
    w_grant     = reset_n && (r_state == ST_IDLE) && (m0_ar_valid || m1_ar_valid);
    w_beat      = (r_state == ST_DATA) && s_r_valid;
    // Counter holds beats already received, so it equals len on the final beat.
    w_cnt_match = (r_cnt == {1'b0, r_len});
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)               w_state_nxt = ST_ADDR;
      ST_ADDR: if (s_ar_ready)            w_state_nxt = ST_DATA;
      ST_DATA: if (w_beat && s_r_last)    w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m0_ar_ready = w_grant && !w_win;
    m1_ar_ready = w_grant && w_win;
    s_ar_valid  = (r_state == ST_ADDR);
    s_r_ready   = (r_state == ST_DATA);
    busy        = (r_state != ST_IDLE);
    s_ar_id     = ID_W'(r_owner);
    s_addr      = r_addr;
    s_len       = r_len;
    s_size      = r_size;
    m0_r_valid  = w_beat && !r_owner;
    m1_r_valid  = w_beat && r_owner;
    m0_r_data   = s_r_data;
    m0_r_resp   = s_r_resp;
    m0_r_last   = s_r_last;
    m1_r_data   = s_r_data;
    m1_r_resp   = s_r_resp;
    m1_r_last   = s_r_last;
    err_len     = w_beat && (s_r_last ^ w_cnt_match);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_cnt        <= '0;
    end else if (w_grant) begin
      r_last_grant <= w_win;
      r_owner      <= w_win;
      r_addr       <= w_win ? m1_addr : m0_addr;
      r_len        <= w_win ? m1_len  : m0_len;
      r_size       <= w_win ? m1_size : m0_size;
      r_cnt        <= '0;
    end else if (w_beat && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: one round-robin and one fixed-priority instance,
// directed stimulus pushes expected grants/requests/beats, a negedge monitor pops and compares.
module tb_axi_rd_arbiter;

  typedef struct packed {
    logic        m0_ar_ready;
    logic        m0_r_valid;
    logic [63:0] m0_r_data;
    logic [1:0]  m0_r_resp;
    logic        m0_r_last;
    logic        m1_ar_ready;
    logic        m1_r_valid;
    logic [63:0] m1_r_data;
    logic [1:0]  m1_r_resp;
    logic        m1_r_last;
    logic        s_ar_valid;
    logic [3:0]  s_ar_id;
    logic [63:0] s_addr;
    logic [7:0]  s_len;
    logic [1:0]  s_size;
    logic        s_r_ready;
    logic        err_len;
    logic        busy;
  } dut_out_t;

  typedef struct {
    logic        mst;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  size;
  } ar_t;

  typedef struct {
    logic        mst;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        err;
  } beat_t;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        rst0, rst1;
  logic        m0_ar_valid, m1_ar_valid;
  logic [63:0] m0_addr, m1_addr;
  logic [7:0]  m0_len, m1_len;
  logic [1:0]  m0_size, m1_size;
  logic        s_ar_ready, s_r_valid, s_r_last;
  logic [63:0] s_r_data;
  logic [1:0]  s_r_resp;
  dut_out_t    o0, o1, d;

  int checks = 0;
  int errors = 0;

  logic  exp_grant[$];
  ar_t   exp_ar[$];
  beat_t exp_beat[$];

  assign rst0 = reset_n && !sel;
  assign rst1 = reset_n && sel;
  assign d    = sel ? o1 : o0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .LEN_W(8), .ID_W(4), .RR_EN(1'b1)) u_rr (
    .clk(clk), .reset_n(rst0),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(o0.m0_ar_ready), .m0_addr(m0_addr), .m0_len(m0_len),
    .m0_size(m0_size), .m0_r_valid(o0.m0_r_valid), .m0_r_data(o0.m0_r_data), .m0_r_resp(o0.m0_r_resp),
    .m0_r_last(o0.m0_r_last),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(o0.m1_ar_ready), .m1_addr(m1_addr), .m1_len(m1_len),
    .m1_size(m1_size), .m1_r_valid(o0.m1_r_valid), .m1_r_data(o0.m1_r_data), .m1_r_resp(o0.m1_r_resp),
    .m1_r_last(o0.m1_r_last),
    .s_ar_valid(o0.s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(o0.s_ar_id), .s_addr(o0.s_addr),
    .s_len(o0.s_len), .s_size(o0.s_size), .s_r_valid(s_r_valid), .s_r_ready(o0.s_r_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .err_len(o0.err_len), .busy(o0.busy)
  );

  axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64), .LEN_W(8), .ID_W(4), .RR_EN(1'b0)) u_fp (
    .clk(clk), .reset_n(rst1),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(o1.m0_ar_ready), .m0_addr(m0_addr), .m0_len(m0_len),
    .m0_size(m0_size), .m0_r_valid(o1.m0_r_valid), .m0_r_data(o1.m0_r_data), .m0_r_resp(o1.m0_r_resp),
    .m0_r_last(o1.m0_r_last),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(o1.m1_ar_ready), .m1_addr(m1_addr), .m1_len(m1_len),
    .m1_size(m1_size), .m1_r_valid(o1.m1_r_valid), .m1_r_data(o1.m1_r_data), .m1_r_resp(o1.m1_r_resp),
    .m1_r_last(o1.m1_r_last),
    .s_ar_valid(o1.s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(o1.s_ar_id), .s_addr(o1.s_addr),
    .s_len(o1.s_len), .s_size(o1.s_size), .s_r_valid(s_r_valid), .s_r_ready(o1.s_r_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .err_len(o1.err_len), .busy(o1.busy)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=none t=%0t", name, act, $time);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    logic  g;
    ar_t   a;
    beat_t b;
    if (d.m0_ar_ready || d.m1_ar_ready) begin
      if (exp_grant.size() == 0) fail_now("unexpected_grant", {62'd0, d.m1_ar_ready, d.m0_ar_ready});
      else begin
        g = exp_grant.pop_front();
        chk("grant", {62'd0, d.m1_ar_ready, d.m0_ar_ready}, g ? 64'd2 : 64'd1);
      end
    end
    if (d.s_ar_valid && s_ar_ready) begin
      if (exp_ar.size() == 0) fail_now("unexpected_ar", d.s_addr);
      else begin
        a = exp_ar.pop_front();
        chk("ar_id",   {60'd0, d.s_ar_id}, {63'd0, a.mst});
        chk("ar_addr", d.s_addr, a.addr);
        chk("ar_len",  {56'd0, d.s_len}, {56'd0, a.len});
        chk("ar_size", {62'd0, d.s_size}, {62'd0, a.size});
      end
    end
    if (d.m0_r_valid || d.m1_r_valid) begin
      if (exp_beat.size() == 0) fail_now("unexpected_beat", s_r_data);
      else begin
        b = exp_beat.pop_front();
        chk("r_owner", {62'd0, d.m1_r_valid, d.m0_r_valid}, b.mst ? 64'd2 : 64'd1);
        chk("r_data", b.mst ? d.m1_r_data : d.m0_r_data, b.data);
        chk("r_resp", {62'd0, (b.mst ? d.m1_r_resp : d.m0_r_resp)}, {62'd0, b.resp});
        chk("r_last", {63'd0, (b.mst ? d.m1_r_last : d.m0_r_last)}, {63'd0, b.last});
        chk("err_len", {63'd0, d.err_len}, {63'd0, b.err});
      end
    end else if (d.err_len) begin
      fail_now("spurious_err_len", 64'd1);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_busy"},      {63'd0, d.busy}, 64'd0);
    chk({tag, "_s_ar_valid"},{63'd0, d.s_ar_valid}, 64'd0);
    chk({tag, "_s_r_ready"}, {63'd0, d.s_r_ready}, 64'd0);
    chk({tag, "_ar_ready"},  {62'd0, d.m1_ar_ready, d.m0_ar_ready}, 64'd0);
    chk({tag, "_r_valid"},   {62'd0, d.m1_r_valid, d.m0_r_valid}, 64'd0);
    chk({tag, "_err_len"},   {63'd0, d.err_len}, 64'd0);
    chk({tag, "_s_ar_id"},   {60'd0, d.s_ar_id}, 64'd0);
    chk({tag, "_s_addr"},    d.s_addr, 64'd0);
    chk({tag, "_s_len"},     {56'd0, d.s_len}, 64'd0);
    chk({tag, "_s_size"},    {62'd0, d.s_size}, 64'd0);
  endtask

  task automatic do_reset(input logic which);
    reset_n = 1'b0;
    sel     = which;
    cyc(); cyc(); cyc();
    reset_n = 1'b1;
  endtask

  task automatic req(input logic mst, input logic [63:0] addr, input logic [7:0] len,
                     input logic [1:0] size);
    if (mst) begin
      m1_addr = addr; m1_len = len; m1_size = size; m1_ar_valid = 1'b1;
    end else begin
      m0_addr = addr; m0_len = len; m0_size = size; m0_ar_valid = 1'b1;
    end
  endtask

  task automatic wait_ar(output bit ok);
    int t;
    t = 0;
    while (!d.s_ar_valid && t < 20) begin
      cyc();
      t++;
    end
    ok = d.s_ar_valid;
    if (!ok) fail_now("timeout_s_ar_valid", 64'd0);
  endtask

  // One transaction seen from the downstream side; expectations are pushed up front.
  task automatic do_txn(input logic mst, input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] size, input int nbeats, input int last_at,
                        input int ar_delay, input bit poke_m0, input logic [1:0] drop,
                        input logic [63:0] base);
    ar_t   a;
    beat_t b;
    bit    ok;
    exp_grant.push_back(mst);
    a.mst = mst; a.addr = addr; a.len = len; a.size = size;
    exp_ar.push_back(a);
    for (int i = 0; i < nbeats; i++) begin
      b.mst  = mst;
      b.data = base + 64'(i);
      b.resp = 2'(i);
      b.last = (i == last_at);
      b.err  = (i == int'(len)) != (i == last_at);
      exp_beat.push_back(b);
    end
    wait_ar(ok);
    if (!ok) return;
    for (int k = 0; k < ar_delay; k++) begin
      chk("bp_s_ar_valid", {63'd0, d.s_ar_valid}, 64'd1);
      chk("bp_s_addr", d.s_addr, addr);
      if (poke_m0) begin
        if (k == 0) m0_ar_valid = 1'b1;
        #1;
        chk("bp_m0_ar_ready", {63'd0, d.m0_ar_ready}, 64'd0);
      end
      cyc();
    end
    s_ar_ready = 1'b1;
    cyc();
    s_ar_ready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_r_valid = 1'b1;
      s_r_data  = base + 64'(i);
      s_r_resp  = 2'(i);
      s_r_last  = (i == last_at);
      if (i == nbeats - 1) begin
        if (drop[0]) m0_ar_valid = 1'b0;
        if (drop[1]) m1_ar_valid = 1'b0;
      end
      cyc();
    end
    s_r_valid = 1'b0;
    s_r_last  = 1'b0;
    chk("busy_after_last", {63'd0, d.busy}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    beat_t b;
    ar_t   a;
    bit    ok;
    reset_n = 1'b0; sel = 1'b0;
    m0_ar_valid = 1'b0; m1_ar_valid = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_len = '0; m1_len = '0; m0_size = '0; m1_size = '0;
    s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_last = 1'b0; s_r_data = '0; s_r_resp = '0;
    cyc(); cyc();
    check_reset_outs("reset");
    reset_n = 1'b1;
    cyc();

    // Single m0 request
    req(1'b0, 64'h8000_0010, 8'd0, 2'b11);
    do_txn(1'b0, 64'h8000_0010, 8'd0, 2'b11, 1, 0, 0, 1'b0, 2'b01, 64'h1122334455667788);
    cyc();

    // Round-robin tie from reset, strict alternation
    do_reset(1'b0);
    req(1'b0, 64'h0000_1000, 8'd0, 2'b10);
    req(1'b1, 64'h0000_2000, 8'd0, 2'b01);
    do_txn(1'b0, 64'h0000_1000, 8'd0, 2'b10, 1, 0, 0, 1'b0, 2'b00, 64'hA000);
    do_txn(1'b1, 64'h0000_2000, 8'd0, 2'b01, 1, 0, 0, 1'b0, 2'b00, 64'hB000);
    do_txn(1'b0, 64'h0000_1000, 8'd0, 2'b10, 1, 0, 0, 1'b0, 2'b00, 64'hA100);
    do_txn(1'b1, 64'h0000_2000, 8'd0, 2'b01, 1, 0, 0, 1'b0, 2'b11, 64'hB100);
    cyc();

    // Bursts on m1: clean, early last, missing last at count==len
    req(1'b1, 64'h0000_3000, 8'd3, 2'b11);
    do_txn(1'b1, 64'h0000_3000, 8'd3, 2'b11, 4, 3, 0, 1'b0, 2'b10, 64'hC000);
    cyc();
    req(1'b1, 64'h0000_3100, 8'd3, 2'b11);
    do_txn(1'b1, 64'h0000_3100, 8'd3, 2'b11, 2, 1, 0, 1'b0, 2'b10, 64'hC100);
    cyc();
    req(1'b1, 64'h0000_3200, 8'd1, 2'b10);
    do_txn(1'b1, 64'h0000_3200, 8'd1, 2'b10, 3, 2, 0, 1'b0, 2'b10, 64'hC200);
    cyc();

    // Downstream backpressure; m0 arrives while busy and is served next
    m0_addr = 64'h0000_4000; m0_len = 8'd0; m0_size = 2'b00;
    req(1'b1, 64'h0000_5000, 8'd0, 2'b01);
    do_txn(1'b1, 64'h0000_5000, 8'd0, 2'b01, 1, 0, 5, 1'b1, 2'b10, 64'hD000);
    do_txn(1'b0, 64'h0000_4000, 8'd0, 2'b00, 1, 0, 0, 1'b0, 2'b01, 64'hD100);
    cyc();

    // Fixed priority: m1 wins every tie
    do_reset(1'b1);
    req(1'b0, 64'h0000_6000, 8'd0, 2'b11);
    req(1'b1, 64'h0000_7000, 8'd0, 2'b11);
    do_txn(1'b1, 64'h0000_7000, 8'd0, 2'b11, 1, 0, 0, 1'b0, 2'b00, 64'hE000);
    do_txn(1'b1, 64'h0000_7000, 8'd0, 2'b11, 1, 0, 0, 1'b0, 2'b00, 64'hE100);
    do_txn(1'b1, 64'h0000_7000, 8'd0, 2'b11, 1, 0, 0, 1'b0, 2'b11, 64'hE200);
    cyc();

    // Reset in the middle of a len=3 burst
    req(1'b1, 64'h0000_8000, 8'd3, 2'b10);
    exp_grant.push_back(1'b1);
    a.mst = 1'b1; a.addr = 64'h0000_8000; a.len = 8'd3; a.size = 2'b10;
    exp_ar.push_back(a);
    b.mst = 1'b1; b.data = 64'hF000; b.resp = 2'd0; b.last = 1'b0; b.err = 1'b0;
    exp_beat.push_back(b);
    wait_ar(ok);
    if (ok) begin
      s_ar_ready = 1'b1;
      cyc();
      s_ar_ready  = 1'b0;
      m1_ar_valid = 1'b0;
      s_r_valid = 1'b1; s_r_data = 64'hF000; s_r_resp = 2'd0; s_r_last = 1'b0;
      cyc();
      s_r_valid = 1'b0;
      reset_n   = 1'b0;
      cyc();
      check_reset_outs("mid_reset");
      s_r_valid = 1'b1; s_r_data = 64'hF001; s_r_last = 1'b1;
      cyc();
      reset_n = 1'b1;
      #1;
      chk("stray_r_valid", {62'd0, d.m1_r_valid, d.m0_r_valid}, 64'd0);
      chk("stray_err_len", {63'd0, d.err_len}, 64'd0);
      chk("stray_s_r_ready", {63'd0, d.s_r_ready}, 64'd0);
      cyc();
      s_r_valid = 1'b0; s_r_last = 1'b0;
    end
    cyc(); cyc();

    chk("left_grant", 64'(exp_grant.size()), 64'd0);
    chk("left_ar",    64'(exp_ar.size()), 64'd0);
    chk("left_beat",  64'(exp_beat.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
